video_timing_gen: RTL and testbench

Raster timing generator and pixel-fetch sequencer feeding the HDMI/TMDS output stage. It counts horizontal/vertical positions in the `pixel_clk` domain and issues per-pixel fetch requests to the frame source. It then aligns the returned RGB with `vde`/`hsync`/`vsync` through a fixed-latency delay line. Its outputs connect directly to the `red`/`green`/`blue`/`vde`/`hsync`/`vsync` inputs of the HDMI interface.

---
 rtl/video_timing_gen.sv | 109 ++++++++++
 tb/tb_video_timing_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, per-pixel fetch requests and a LATENCY-matched delay line aligning returned RGB with vde/hsync/vsync.
// Define VIDEO_TEST_PATTERN_EN to add the test_pattern input and the 8-bar colour generator.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int LATENCY   = 2
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
`ifdef VIDEO_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic        req_valid,
  output logic [11:0] req_x,
  output logic [11:0] req_y,
  output logic        frame_start,
  input  logic [23:0] rgb_in,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        vde,
  output logic        hsync,
  output logic        vsync
);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] HA     = 12'(H_ACTIVE);
  localparam logic [11:0] VA     = 12'(V_ACTIVE);
  localparam logic [11:0] HS0    = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS0    = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1    = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HP     = (HSYNC_POL != 0);
  localparam logic        VP     = (VSYNC_POL != 0);
  // Stage word {[tp_en, bar[2:0],] active, raw hsync, raw vsync}
`ifdef VIDEO_TEST_PATTERN_EN
  localparam int SW = 7;
`else
  localparam int SW = 3;
`endif
  logic [11:0]                h_q, h_d, v_q, v_d;
  logic [11:0]                x_q, y_q;
  logic                       fs_q, fs_d;
  logic [SW-1:0]              st_q, st_d;
  logic [LATENCY-1:0][SW-1:0] dly_q;
  logic [LATENCY:0][SW-1:0]   sh;
  logic [SW-1:0]              tail;
  logic                       vde_q, hs_q, vs_q;
  logic [23:0]                rgb_q, rgb_d;
  assign sh   = {dly_q, st_q};
  assign tail = sh[LATENCY];
  always_comb begin
    h_d  = (h_q == H_LAST) ? 12'd0 : h_q + 12'd1;
    v_d  = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
    fs_d = (h_q == 12'd0) && (v_q == 12'd0);
`ifdef VIDEO_TEST_PATTERN_EN
    // st_q[6] is the frame's held pattern enable, refreshed only at (0,0)
    st_d = {fs_d ? test_pattern : st_q[6], 3'({h_q, 3'b000} / 15'(H_ACTIVE)),
            (h_q < HA) && (v_q < VA), (h_q >= HS0) && (h_q < HS1), (v_q >= VS0) && (v_q < VS1)};
    rgb_d = !tail[2] ? 24'd0 : tail[6] ? {{8{~tail[4]}}, {8{~tail[5]}}, {8{~tail[3]}}} : rgb_in;
`else
    st_d  = {(h_q < HA) && (v_q < VA), (h_q >= HS0) && (h_q < HS1), (v_q >= VS0) && (v_q < VS1)};
    rgb_d = tail[2] ? rgb_in : 24'd0;
`endif
  end
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q   <= '0;
      v_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
      st_q  <= '0;
      dly_q <= '0;
      vde_q <= 1'b0;
      hs_q  <= ~HP;
      vs_q  <= ~VP;
      rgb_q <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      x_q   <= h_q;
      y_q   <= v_q;
      fs_q  <= fs_d;
      st_q  <= st_d;
      dly_q <= sh[LATENCY-1:0];
      vde_q <= tail[2];
      hs_q  <= tail[1] ? HP : ~HP;
      vs_q  <= tail[0] ? VP : ~VP;
      rgb_q <= rgb_d;
    end
  end
  assign req_valid   = st_q[2];
  assign req_x       = x_q;
  assign req_y       = y_q;
  assign frame_start = fs_q;
  assign vde         = vde_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign {red, green, blue} = rgb_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: four generator configurations checked every cycle against an arithmetic raster model.
module tb_video_timing_gen;
  localparam int N = 4;
  localparam int HA_T  [N] = '{640, 8, 8, 8};
  localparam int HF_T  [N] = '{16, 2, 2, 2};
  localparam int HS_T  [N] = '{96, 3, 3, 3};
  localparam int HB_T  [N] = '{48, 3, 3, 3};
  localparam int VA_T  [N] = '{480, 4, 4, 4};
  localparam int VF_T  [N] = '{10, 1, 1, 1};
  localparam int VS_T  [N] = '{2, 2, 2, 2};
  localparam int VB_T  [N] = '{33, 2, 2, 2};
  localparam int HP_T  [N] = '{0, 0, 1, 1};
  localparam int VP_T  [N] = '{0, 0, 1, 0};
  localparam int LAT_T [N] = '{2, 1, 4, 15};
  localparam logic [23:0] BAR [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  typedef struct packed {logic act, hs, vs, fs; logic [11:0] x, y;} req_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv [N], fs [N], de [N], hs [N], vs [N];
  logic [11:0] rx [N], ry [N];
  logic [23:0] rgb_in [N];
  logic [7:0]  r [N], g [N], b [N];
`ifdef VIDEO_TEST_PATTERN_EN
  logic        tp = 1'b0;
`endif
  bit          tp_mode = 1'b0;
  int          k = 0;
  int          tests = 0, fails = 0;
  int          rvr [N] = '{default: -1};
  int          der [N] = '{default: -1};
  int          hsf = -1, hsr = -1, de2 = -1, fs1 = -1, fs2 = -1;
  logic        rv_p [N] = '{default: 1'b0};
  logic        de_p [N] = '{default: 1'b0};
  logic        hs0_p = 1'b1;
  always #5 clk = ~clk;
  for (genvar i = 0; i < N; i++) begin : g_dut
    video_timing_gen #(
      .H_ACTIVE(HA_T[i]), .H_FP(HF_T[i]), .H_SYNC(HS_T[i]), .H_BP(HB_T[i]),
      .V_ACTIVE(VA_T[i]), .V_FP(VF_T[i]), .V_SYNC(VS_T[i]), .V_BP(VB_T[i]),
      .HSYNC_POL(HP_T[i]), .VSYNC_POL(VP_T[i]), .LATENCY(LAT_T[i])
    ) u_dut (
      .pixel_clk(clk), .reset_n(rst_n),
`ifdef VIDEO_TEST_PATTERN_EN
      .test_pattern(tp),
`endif
      .req_valid(rv[i]), .req_x(rx[i]), .req_y(ry[i]), .frame_start(fs[i]),
      .rgb_in(rgb_in[i]), .red(r[i]), .green(g[i]), .blue(b[i]),
      .vde(de[i]), .hsync(hs[i]), .vsync(vs[i])
    );
  end
  always @(posedge clk or negedge rst_n) k <= !rst_n ? 0 : k + 1;
  // Request issued on clock edge n (n >= 1) after reset release; n < 1 is the reset state
  function automatic req_t req_at(int i, int n);
    req_t q;
    int ht, vt, p, h, v;
    q = '0;
    if (n < 1) return q;
    ht = HA_T[i] + HF_T[i] + HS_T[i] + HB_T[i];
    vt = VA_T[i] + VF_T[i] + VS_T[i] + VB_T[i];
    p = (n - 1) % (ht * vt);
    h = p % ht;
    v = p / ht;
    q.act = (h < HA_T[i]) && (v < VA_T[i]);
    q.hs = (h >= HA_T[i] + HF_T[i]) && (h < HA_T[i] + HF_T[i] + HS_T[i]);
    q.vs = (v >= VA_T[i] + VF_T[i]) && (v < VA_T[i] + VF_T[i] + VS_T[i]);
    q.fs = (p == 0);
    q.x = 12'(h);
    q.y = 12'(v);
    return q;
  endfunction
  function automatic logic [23:0] src(req_t q);
    return {q.x[7:0], q.y[7:0], 8'h5A};
  endfunction
  function automatic logic [23:0] pix(int i, req_t q);
    if (!q.act) return 24'd0;
    if (tp_mode) return BAR[(int'(q.x) * 8) / HA_T[i]];
    return src(q);
  endfunction
  task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      if (fails <= 30) $display("FAIL %s[%0d] k=%0d got %0h want %0h", nm, i, k, got, want);
    end
  endtask
  always @(negedge clk) begin
    req_t q, o;
    for (int i = 0; i < N; i++) begin
      q = req_at(i, k);
      o = req_at(i, k - LAT_T[i] - 1);
      chk("req_valid", i, rv[i], q.act);
      chk("req_x", i, rx[i], q.x);
      chk("req_y", i, ry[i], q.y);
      chk("frame_start", i, fs[i], q.fs);
      chk("vde", i, de[i], o.act);
      chk("hsync", i, hs[i], logic'(o.hs == (HP_T[i] != 0)));
      chk("vsync", i, vs[i], logic'(o.vs == (VP_T[i] != 0)));
      chk("rgb", i, {r[i], g[i], b[i]}, pix(i, o));
      if (rv[i] && !rv_p[i] && rvr[i] < 0) rvr[i] = k;
      if (de[i] && !de_p[i]) begin
        if (der[i] < 0) der[i] = k;
        else if (i == 0 && de2 < 0) de2 = k;
      end
      rv_p[i] = rv[i];
      de_p[i] = de[i];
      rgb_in[i] = src(req_at(i, k - LAT_T[i]));
    end
    if (!hs[0] && hs0_p && hsf < 0) hsf = k;
    if (hs[0] && !hs0_p && hsf >= 0 && hsr < 0) hsr = k;
    hs0_p = hs[0];
    if (fs[1]) begin
      if (fs1 < 0) fs1 = k;
      else if (fs2 < 0) fs2 = k;
    end
  end
  task automatic run_phase();
    @(negedge clk);
    chk("fs_cycle1", 0, fs[0], 1);
    chk("rv_cycle1", 0, rv[0], 1);
    repeat (2) @(negedge clk);
    chk("vde_before_first", 0, de[0], 0);
    @(negedge clk);
    chk("vde_first", 0, de[0], 1);
    chk("rgb_x0", 0, {r[0], g[0], b[0]}, tp_mode ? 24'hFFFFFF : 24'h00005A);
    repeat (639) @(negedge clk);
    chk("rgb_x639", 0, {r[0], g[0], b[0]}, tp_mode ? 24'h000000 : 24'h7F005A);
  endtask
  initial begin
    req_t m;
    for (int i = 0; i < N; i++) rgb_in[i] = 24'd0;
    m = req_at(0, 1);       chk("model_fs0", 0, m.fs, 1);
    m = req_at(0, 640);     chk("model_act639", 0, m.act, 1);
    m = req_at(0, 641);     chk("model_act640", 0, m.act, 0);
    m = req_at(0, 656);     chk("model_hs655", 0, m.hs, 0);
    m = req_at(0, 657);     chk("model_hs656", 0, m.hs, 1);
    m = req_at(0, 753);     chk("model_hs752", 0, m.hs, 0);
    m = req_at(0, 489*800 + 800); chk("model_vs489", 0, m.vs, 0);
    m = req_at(0, 490*800 + 1);   chk("model_vs490", 0, m.vs, 1);
    m = req_at(0, 492*800 + 1);   chk("model_vs492", 0, m.vs, 0);
    m = req_at(0, 525*800);       chk("model_last_y", 0, m.y, 524);
    m = req_at(0, 420001);        chk("model_frame_wrap", 0, m.fs, 1);
    repeat (3) @(negedge clk);
    chk("rst_hsync", 0, hs[0], 1);
    chk("rst_vsync", 0, vs[0], 1);
    chk("rst_hsync_pos", 2, hs[2], 0);
    chk("rst_vsync_pos", 2, vs[2], 0);
    rst_n = 1'b1;
    run_phase();
    for (int n = 0; n < 5000 && k != 1901; n++) @(negedge clk);
    chk("reach_midline", 0, k, 1901);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("mid_rst_rv", i, rv[i], 0);
      chk("mid_rst_fs", i, fs[i], 0);
      chk("mid_rst_vde", i, de[i], 0);
      chk("mid_rst_rgb", i, {r[i], g[i], b[i]}, 0);
      chk("mid_rst_hs", i, hs[i], logic'(HP_T[i] == 0));
      chk("mid_rst_vs", i, vs[i], logic'(VP_T[i] == 0));
    end
`ifdef VIDEO_TEST_PATTERN_EN
    tp = 1'b1;
    tp_mode = 1'b1;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_phase();
    repeat (300) @(negedge clk);
    for (int i = 0; i < N; i++) chk("vde_lag", i, der[i] - rvr[i], LAT_T[i] + 1);
    chk("hs_start", 0, hsf - der[0], 656);
    chk("hs_width", 0, hsr - hsf, 96);
    chk("line_period", 0, de2 - der[0], 800);
    chk("frame_period", 1, fs2 - fs1, 144);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
